// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, valid/ready on both sides.
// Optional DIV_SIGNED_EN: two's-complement operands, truncating division, one extra
// FIX cycle to restore signs. Default build is unsigned with latency WIDTH.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
`ifdef DIV_SIGNED_EN
  localparam logic [1:0] StFix  = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;         // working partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;         // working dividend/quotient shift register
  logic [WIDTH-1:0] dvs_q, dvs_d;         // latched divisor (magnitude in signed mode)
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic             accept;
  logic             divisor_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   rem_sh;
  logic             trial_ok;
  logic [WIDTH-1:0] trial_low;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             last_step;

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign div_by_zero  = dbz_q;
  assign accept       = in_valid & in_ready;
  assign divisor_zero = (divisor == '0);

  // Operand conditioning: magnitudes and sign flags for the signed variant.
  always_comb begin
`ifdef DIV_SIGNED_EN
    a_neg = dividend[WIDTH-1];
    b_neg = divisor[WIDTH-1];
    a_mag = a_neg ? (-dividend) : dividend;
    b_mag = b_neg ? (-divisor) : divisor;
`else
    a_neg = 1'b0;
    b_neg = 1'b0;
    a_mag = dividend;
    b_mag = divisor;
`endif
  end

  // One restoring step. The shifted remainder keeps its carry-out bit so divisors
  // with the MSB set still compare correctly; a successful trial always fits WIDTH bits.
  always_comb begin
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    trial_ok  = (rem_sh >= {1'b0, dvs_q});
    trial_low = WIDTH'(rem_sh - {1'b0, dvs_q});
    rem_step  = trial_ok ? trial_low : rem_sh[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], trial_ok};
    last_step = (cnt_q == CntOne);
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (divisor_zero) begin
            // Divide by zero bypasses the iteration entirely.
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = StDone;
          end else begin
            dvs_d   = b_mag;
            quo_d   = a_mag;
            rem_d   = '0;
            cnt_d   = CntInit;
            state_d = StBusy;
`ifdef DIV_SIGNED_EN
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
`endif
          end
        end
      end
      StBusy: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CntOne;
        if (last_step) begin
`ifdef DIV_SIGNED_EN
          state_d = StFix;
`else
          quotient_d  = quo_step;
          remainder_d = rem_step;
          dbz_d       = 1'b0;
          state_d     = StDone;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      StFix: begin
        // Most-negative / -1 wraps naturally: magnitude 2^(W-1) reinterpreted.
        quotient_d  = neg_quo_q ? (-quo_q) : quo_q;
        remainder_d = neg_rem_q ? (-rem_q) : rem_q;
        dbz_d       = 1'b0;
        state_d     = StDone;
      end
`endif
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=16). Build with DIV_SIGNED_EN to cover
// the signed variant; expectations switch accordingly.
module tb_seq_divider;
  localparam int W = 16;
`ifdef DIV_SIGNED_EN
  localparam int Lat = W + 1;
`else
  localparam int Lat = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One division; elat counts edges after the accept edge until out_valid is seen.
  // While the unit is busy, in_valid stays high with junk operands that must be ignored.
  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int stall, input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic ez, input int elat);
    int   lat;
    logic busy_ready;
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    dividend   = ~a;
    divisor    = 16'h0003;
    lat        = 0;
    busy_ready = out_valid ? 1'b0 : in_ready;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid) busy_ready |= in_ready;
    end
    in_valid = 1'b0;
    check($sformatf("%s.lat", tag), lat, elat);
    check($sformatf("%s.busy_ready", tag), busy_ready, 1'b0);
    check($sformatf("%s.done_ready", tag), in_ready, 1'b0);
    check($sformatf("%s.q", tag), quotient, eq);
    check($sformatf("%s.r", tag), remainder, er);
    check($sformatf("%s.dbz", tag), div_by_zero, ez);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s.hold_v%0d", tag, i), out_valid, 1'b1);
      check($sformatf("%s.hold_q%0d", tag, i), quotient, eq);
      check($sformatf("%s.hold_r%0d", tag, i), remainder, er);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("%s.idle_ready", tag), in_ready, 1'b1);
    check($sformatf("%s.idle_valid", tag), out_valid, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.q", quotient, 16'h0000);
    check("rst.r", remainder, 16'h0000);
    check("rst.dbz", div_by_zero, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run("100/7", 16'd100, 16'd7, 0, 16'd14, 16'd2, 1'b0, Lat);
    run("ffff/1", 16'hFFFF, 16'h0001, 0, 16'hFFFF, 16'h0000, 1'b0, Lat);
    run("5/9", 16'h0005, 16'h0009, 0, 16'h0000, 16'h0005, 1'b0, Lat);
    // Zero divisor: result is visible in the cycle right after the accept edge.
    run("1234/0", 16'h1234, 16'h0000, 0, 16'hFFFF, 16'h1234, 1'b1, 0);
`ifdef DIV_SIGNED_EN
    run("c350/3", 16'hC350, 16'd3, 10, 16'hEBC6, 16'hFFFE, 1'b0, Lat);
    run("ffff/ffff", 16'hFFFF, 16'hFFFF, 0, 16'h0001, 16'h0000, 1'b0, Lat);
    run("fffe/8001", 16'hFFFE, 16'h8001, 0, 16'h0000, 16'hFFFE, 1'b0, Lat);
    run("-7/2", 16'hFFF9, 16'h0002, 0, 16'hFFFD, 16'hFFFF, 1'b0, Lat);
    run("7/-2", 16'h0007, 16'hFFFE, 0, 16'hFFFD, 16'h0001, 1'b0, Lat);
    run("min/-1", 16'h8000, 16'hFFFF, 0, 16'h8000, 16'h0000, 1'b0, Lat);
`else
    run("50000/3", 16'd50000, 16'd3, 10, 16'd16666, 16'd2, 1'b0, Lat);
    run("ffff/ffff", 16'hFFFF, 16'hFFFF, 0, 16'h0001, 16'h0000, 1'b0, Lat);
    run("fffe/8001", 16'hFFFE, 16'h8001, 0, 16'h0001, 16'h7FFD, 1'b0, Lat);
    run("c000/8001", 16'hC000, 16'h8001, 0, 16'h0001, 16'h3FFF, 1'b0, Lat);
`endif

    // Abort in the middle of an iteration.
    in_valid = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort.busy_ready", in_ready, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort.in_ready", in_ready, 1'b1);
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.q", quotient, 16'h0000);
    check("abort.r", remainder, 16'h0000);
    run("9/4", 16'd9, 16'd4, 0, 16'd2, 16'd1, 1'b0, Lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
